// File: rtl/progetto_labdig_if.sv
// REG_BUS: simple valid/ready register bus; `in` is the slave side, `out` the master side.
interface REG_BUS #(
    parameter int ADDR_WIDTH = 2,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   addr;
    logic                    write;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    valid;
    logic [DATA_WIDTH-1:0]   rdata;
    logic                    error;
    logic                    ready;
    modport in  (input addr, write, wdata, wstrb, valid, output rdata, error, ready);
    modport out (output addr, write, wdata, wstrb, valid, input rdata, error, ready);
endinterface

// File: rtl/progetto_labdig.sv
// progetto_labdig: bit-flip rate monitor with interval interrupt and 4-word REG_BUS status slave.
// Optional LABDIG_IRQ_W1C_EN: write 1 to bit 0 of addr 0 clears the interrupt.
module progetto_labdig #(
    parameter int CYCLE_LIM     = 100,
    parameter int IN_DATA_WIDTH = 100
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [IN_DATA_WIDTH-1:0] scrub_i,
    REG_BUS.in                       bus_if,
    output logic                     interr_o
);
    localparam int PW = $clog2(IN_DATA_WIDTH + 1);
    logic [PW-1:0] pop;
    logic [31:0]   cnt_q;
    logic [31:0]   cyclesxbf_q;
    logic [PW-1:0] bfdensity_q;
    logic          seen_q;
    logic          interr_q;
    logic          ev;
    logic          multi;
    logic          eval;
    logic          clr;
    always_comb begin
        pop = '0;
        for (int i = 0; i < IN_DATA_WIDTH; i++) pop = pop + PW'(scrub_i[i]);
    end
    assign ev    = pop != '0;
    assign multi = pop > PW'(1);
    // an event re-evaluates the interrupt only when it defines an interval
    assign eval  = ev && (multi || seen_q);
`ifdef LABDIG_IRQ_W1C_EN
    logic unused_bus;
    assign clr = bus_if.valid && bus_if.write && bus_if.addr == 2'd0 && bus_if.wstrb[0] && bus_if.wdata[0];
    assign unused_bus = ^{bus_if.wdata[31:1], bus_if.wstrb[3:1]};
`else
    logic unused_bus;
    assign clr = 1'b0;
    assign unused_bus = ^{bus_if.write, bus_if.wdata, bus_if.wstrb};
`endif
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q       <= '0;
            cyclesxbf_q <= '0;
            bfdensity_q <= '0;
            seen_q      <= 1'b0;
            interr_q    <= 1'b0;
        end else begin
            cnt_q <= ev ? 32'd1 : (&cnt_q ? cnt_q : cnt_q + 32'd1);
            if (ev) begin
                seen_q      <= 1'b1;
                bfdensity_q <= pop;
            end
            if (eval) begin
                cyclesxbf_q <= multi ? 32'd0 : cnt_q;
                interr_q    <= multi || cnt_q < 32'(CYCLE_LIM);
            end else if (clr) begin
                interr_q <= 1'b0;
            end
        end
    end
    assign interr_o     = interr_q;
    assign bus_if.ready = bus_if.valid;
    assign bus_if.error = 1'b0;
    assign bus_if.rdata = !bus_if.valid       ? 32'd0 :
                          bus_if.addr == 2'd0 ? {31'b0, interr_q} :
                          bus_if.addr == 2'd1 ? cyclesxbf_q :
                          bus_if.addr == 2'd2 ? 32'(bfdensity_q) : 32'd0;
endmodule

// File: tb/tb_progetto_labdig.sv
// tb_progetto_labdig: directed + randomized checks against a timestamp-based reference model.
module tb_progetto_labdig;
    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic [99:0] scrub_i = '0;
    logic        interr_o;
    REG_BUS bus ();
    progetto_labdig dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .scrub_i  (scrub_i),
        .bus_if   (bus),
        .interr_o (interr_o)
    );
    always #5 clk_i = ~clk_i;
    int          checks = 0;
    int          errors = 0;
    int          cyc_n = 0;
    int          last_ev = -1;
    logic        m_irq = 1'b0;
    logic [31:0] m_cyc = '0;
    int          m_dens = 0;
    logic        w1c = 1'b0;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask
    task automatic model_reset();
        last_ev = -1;
        m_irq = 1'b0;
        m_cyc = '0;
        m_dens = 0;
    endtask
    // one clock edge with sample s; the model works on event timestamps
    task automatic step(input logic [99:0] s);
        int p;
        scrub_i = s;
        @(posedge clk_i);
        cyc_n++;
        p = $countones(s);
        if (p >= 2) begin
            m_cyc = 0;
            m_irq = 1'b1;
        end else if (p == 1 && last_ev >= 0) begin
            m_cyc = 32'(cyc_n - last_ev);
            m_irq = (cyc_n - last_ev) < 100;
        end else if (w1c) begin
            m_irq = 1'b0;
        end
        if (p != 0) begin
            last_ev = cyc_n;
            m_dens = p;
        end
        #1;
    endtask
    task automatic rd(input logic [1:0] a, output logic [31:0] d, output logic rdy);
        bus.addr = a;
        bus.write = 1'b0;
        bus.valid = 1'b1;
        #1;
        d = bus.rdata;
        rdy = bus.ready;
        bus.valid = 1'b0;
    endtask
    task automatic check_all(input string t);
        logic [31:0] d;
        logic [31:0] exp [4];
        logic        rdy;
        exp[0] = {31'b0, m_irq};
        exp[1] = m_cyc;
        exp[2] = 32'(m_dens);
        exp[3] = 32'd0;
        chk({t, ":irq_o"}, {31'b0, interr_o}, {31'b0, m_irq});
        for (int a = 0; a < 4; a++) begin
            rd(2'(a), d, rdy);
            chk($sformatf("%s:addr%0d", t, a), d, exp[a]);
        end
        chk({t, ":ready"}, {31'b0, rdy}, 32'd1);
    endtask
    function automatic logic [99:0] onehot(input int k);
        logic [99:0] v = '0;
        v[k] = 1'b1;
        return v;
    endfunction
    function automatic logic [99:0] rnd_vec();
        logic [127:0] r = {$urandom, $urandom, $urandom, $urandom};
        return r[99:0];
    endfunction
    initial begin
        logic [31:0] d;
        logic        rdy;
        bus.addr = '0; bus.write = 1'b0; bus.wdata = '0; bus.wstrb = '0; bus.valid = 1'b0;
        rst_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        check_all("reset");
        #1;
        chk("rdata_idle", bus.rdata, 32'd0);
        chk("error_idle", {31'b0, bus.error}, 32'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        repeat (3) step('0);
        check_all("idle");
        step(onehot(3));
        check_all("first_event");
        repeat (98) step('0);
        step(onehot(50));
        check_all("interval99");
        rd(2'd1, d, rdy);
        chk("interval99_const", d, 32'h63);
        chk("irq99_const", {31'b0, interr_o}, 32'd1);
        repeat (99) step('0);
        step(onehot(99));
        check_all("interval100");
        chk("irq100_const", {31'b0, interr_o}, 32'd0);
        repeat (96) step('0);
        step(onehot(0));
        check_all("interval97");
        rd(2'd1, d, rdy);
        chk("interval97_const", d, 32'h61);
        for (int i = 0; i < 15; i++) begin
            int r = $urandom_range(0, 3);
            step(r == 0 ? 100'd0 : r == 1 ? onehot($urandom_range(0, 99)) : rnd_vec());
            check_all($sformatf("rand15_%0d", i));
        end
        step(100'h5);
        check_all("multi");
        rd(2'd1, d, rdy);
        chk("multi_cyc_const", d, 32'd0);
        rd(2'd2, d, rdy);
        chk("multi_dens_const", d, 32'd2);
        bus.addr = 2'd0; bus.write = 1'b1; bus.wdata = 32'h1; bus.wstrb = 4'h1; bus.valid = 1'b1;
`ifdef LABDIG_IRQ_W1C_EN
        w1c = 1'b1;
`endif
        #1;
        chk("write_ready", {31'b0, bus.ready}, 32'd1);
        chk("write_error", {31'b0, bus.error}, 32'd0);
        step('0);
        w1c = 1'b0;
        bus.write = 1'b0; bus.valid = 1'b0; bus.wdata = '0; bus.wstrb = '0;
        check_all("write_addr0");
        step(onehot(7));
        check_all("after_write");
        for (int i = 0; i < 400; i++) begin
            int r = $urandom_range(0, 99);
            int a = $urandom_range(0, 99);
            int b = (a + $urandom_range(1, 99)) % 100;
            step(r < 2 ? (onehot(a) | onehot(b)) : r < 4 ? onehot(a) : 100'd0);
            check_all($sformatf("long_%0d", i));
        end
        repeat (5) step('0);
        rst_i = 1'b1;
        #1;
        model_reset();
        check_all("mid_reset");
        @(negedge clk_i);
        rst_i = 1'b0;
        step(onehot(11));
        check_all("post_reset_first");
        repeat (10) step('0);
        step(onehot(12));
        check_all("post_reset_second");
        chk("post_reset_cyc_const", m_cyc, 32'd11);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/progetto_labdig.md
# progetto_labdig

Bit-flip rate monitor for the memory scrubbing subsystem. Each cycle it samples an IN_DATA_WIDTH-bit vector of per-word flip indications from the scrubber, measures the distance in cycles between consecutive flip events, counts the flips in each sample, and raises an interrupt when two events are closer than CYCLE_LIM cycles. Status is exposed to software through a 4-word REG_BUS register slave.

## Interface
- CYCLE_LIM, 100: interval threshold in cycles; an interval strictly below it raises the interrupt.
- IN_DATA_WIDTH, 100: width of scrub_i, i.e. number of scrubbed words reported per cycle.
- REG_BUS address width 2, data width 32 (fixed by the bus instance; DATA_WIDTH=32 below).
- clk_i  in  1  single clock; all logic on rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- scrub_i  in  IN_DATA_WIDTH  bit k=1: flip detected on word k this cycle.
- bus_if  REG_BUS `in` modport  addr[1:0], write, wdata[31:0], wstrb[3:0], valid, rdata[31:0], error, ready.
- interr_o  out  1  interrupt, equals interr_q.

## Operation
- Sample: pop = popcount(scrub_i) at each rising edge; event = (pop != 0).
- cnt_q (32 bit): edges since last event. On event edge cnt_q <= 1; otherwise cnt_q <= cnt_q+1, saturating at 0xFFFF_FFFF.
- seen_q: set on first event after reset; before it no interval exists.
- On event edge with seen_q=1: interval N = cnt_q (pre-update value); cyclesxbf_q <= N; interr_q <= (N < CYCLE_LIM).
- On event edge with pop >= 2: interval is 0; cyclesxbf_q <= 0; interr_q <= 1 (regardless of seen_q).
- First event after reset with pop=1: only seen_q set; cyclesxbf_q and interr_q unchanged.
- bfdensity_q <= pop on every event edge; held on non-event edges.
- interr_q is level: holds between events, re-evaluated (set or cleared) at every event.
- Register map (read): 0 = {31'b0, interr_q}; 1 = cyclesxbf_q; 2 = bfdensity_q (zero-extended); 3 = 0.
- Bus: ready = 1 combinationally whenever valid; rdata = map[addr] combinationally (0 when valid=0); error = 0 always.
- Writes: see Configuration; otherwise ignored, still acked with ready=1.

## Timing
- Reset: interr_q, interr_o, cyclesxbf_q, bfdensity_q, cnt_q, seen_q all 0; rdata 0.
- Latency: flip sampled at edge E updates registers at E; visible on bus and interr_o immediately after E (1 edge from input change).
- Read: zero wait states, same-cycle data; single-cycle valid suffices.
- Reset asserted mid-operation clears all state immediately; first event after release only arms seen_q.
- Saturated cnt_q yields cyclesxbf_q = 0xFFFF_FFFF and interr_q = 0.
- Write-clear and event on same edge: event evaluation wins.

## Configuration
- LABDIG_IRQ_W1C_EN defined: bus write (valid=1, write=1) to addr 0 with wstrb[0]=1 and wdata[0]=1 clears interr_q on that edge; other writes ignored.
- Not defined: all writes ignored; interrupt cleared only by reset or by a non-violating event.

## Test plan
- Reset, no activity -> interr_o=0, reads of addr 0..3 return 0x0000_0000.
- Single-bit flip, 98 idle cycles, single-bit flip -> interval 99; addr 0 reads 0x0000_0001, interr_o=1, addr 1 reads 0x63.
- Then single-bit flip, 99 idle cycles, single-bit flip -> interval 100; addr 0 reads 0x0000_0000, interr_o=0.
- Single-bit flip, 96 idle, single-bit flip -> addr 1 reads 0x0000_0061, interr_o=1.
- 15 cycles random scrub_i -> addr 2 equals popcount of last nonzero sample; multi-bit sample forces interr_o=1, addr 1 = 0.
- With LABDIG_IRQ_W1C_EN: interrupt set, write 0x1 to addr 0 -> interr_o=0 next cycle; without macro, same write leaves interr_o=1.
